irq_arbiter: RTL and testbench

- Sits directly downstream of the per-peripheral interrupt controllers.
- Collects their irq_req lines, masks them, and selects one winner by priority.
- Presents the winner to the CPU as a single request plus vector, using a request/ack/end-of-interrupt handshake.
- On CPU ack, returns a one-cycle irq_clr pulse to the winning source's controller.

---
 rtl/irq_pkg.sv | 12 +
 rtl/irq_prio_enc.sv | 33 +++
 rtl/irq_arbiter.sv | 127 ++++++++++++
 tb/tb_irq_arbiter.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types and limits for the interrupt arbiter.
package irq_pkg;

    localparam int unsigned IRQ_MAX_SRC = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PEND    = 2'b01,
        SERVICE = 2'b10
    } arb_state_t;

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: first set bit of elig_i at or above base_i, wrapping.
module irq_prio_enc #(
    parameter int unsigned NUM_SRC = 8,
    localparam int unsigned VEC_W = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] elig_i,
    input  logic [VEC_W-1:0]   base_i,
    output logic               valid_o,
    output logic [VEC_W-1:0]   idx_o
);
    import irq_pkg::*;

    int unsigned j;
    logic        found;

    always_comb begin
        found = 1'b0;
        idx_o = '0;
        j     = 0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            j = i + 32'(base_i);
            if (j >= NUM_SRC) begin
                j = j - NUM_SRC;
            end
            if (!found && elig_i[j]) begin
                found = 1'b1;
                idx_o = VEC_W'(j);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/irq_arbiter.sv
// Masks and arbitrates interrupt requests, presents one to the CPU with a req/ack/eoi handshake.
// Define IRQ_ARB_ROUND_ROBIN_EN for round-robin arbitration instead of fixed lowest-index priority.
module irq_arbiter
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC = 8,
    localparam int unsigned VEC_W = $clog2(NUM_SRC)
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [NUM_SRC-1:0] irq_req_i,
    input  logic [NUM_SRC-1:0] irq_mask_i,
    input  logic               cpu_ack_i,
    input  logic               cpu_eoi_i,
    output logic               cpu_irq_o,
    output logic [VEC_W-1:0]   cpu_vec_o,
    output logic [NUM_SRC-1:0] irq_clr_o,
    output logic               busy_o
);

    arb_state_t         state_q, state_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic               irq_q, irq_d;
    logic [NUM_SRC-1:0] clr_q, clr_d;
    logic               busy_q, busy_d;

    logic [NUM_SRC-1:0] eligible;
    logic [VEC_W-1:0]   base;
    logic               win_valid;
    logic [VEC_W-1:0]   win_idx;
    logic [VEC_W-1:0]   vec_next;

    assign eligible = irq_req_i & ~irq_mask_i;
    assign vec_next = (vec_q == VEC_W'(NUM_SRC - 1)) ? '0 : vec_q + VEC_W'(1);

`ifdef IRQ_ARB_ROUND_ROBIN_EN
    logic [VEC_W-1:0] rr_ptr_q, rr_ptr_d;

    assign base = rr_ptr_q;

    // Pointer advances only on an accepted ack; withdrawals leave it alone.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == PEND && cpu_ack_i) begin
            rr_ptr_d = vec_next;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`else
    assign base = '0;
`endif

    irq_prio_enc #(
        .NUM_SRC (NUM_SRC)
    ) u_prio_enc (
        .elig_i  (eligible),
        .base_i  (base),
        .valid_o (win_valid),
        .idx_o   (win_idx)
    );

    always_comb begin
        state_d = state_q;
        vec_d   = vec_q;
        irq_d   = 1'b0;
        clr_d   = '0;
        unique case (state_q)
            IDLE: begin
                if (win_valid) begin
                    vec_d   = win_idx;
                    irq_d   = 1'b1;
                    state_d = PEND;
                end
            end
            PEND: begin
                irq_d = 1'b1;
                // Ack takes precedence over a simultaneous withdrawal or eoi.
                if (cpu_ack_i) begin
                    irq_d        = 1'b0;
                    clr_d[vec_q] = 1'b1;
                    state_d      = SERVICE;
                end else if (!eligible[vec_q]) begin
                    irq_d   = 1'b0;
                    state_d = IDLE;
                end
            end
            SERVICE: begin
                if (cpu_eoi_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == PEND) || (state_d == SERVICE);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            vec_q   <= '0;
            irq_q   <= 1'b0;
            clr_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            vec_q   <= vec_d;
            irq_q   <= irq_d;
            clr_q   <= clr_d;
            busy_q  <= busy_d;
        end
    end

    assign cpu_irq_o = irq_q;
    assign cpu_vec_o = vec_q;
    assign irq_clr_o = clr_q;
    assign busy_o    = busy_q;

endmodule

// File: tb/tb_irq_arbiter.sv
// Directed vector bench for irq_arbiter; honours IRQ_ARB_ROUND_ROBIN_EN for the arbitration sequence.
module tb_irq_arbiter;

    logic       clk;
    logic       rst_n;
    logic [7:0] irq_req;
    logic [7:0] irq_mask;
    logic       cpu_ack;
    logic       cpu_eoi;
    logic       cpu_irq;
    logic [2:0] cpu_vec;
    logic [7:0] irq_clr;
    logic       busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst_n;
        logic [7:0] req;
        logic [7:0] mask;
        logic       ack;
        logic       eoi;
        logic       irq;
        logic [2:0] vec;
        logic [7:0] clr;
        logic       busy;
    } vec_t;

    vec_t tbl[$];

    irq_arbiter #(
        .NUM_SRC (8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .irq_req_i  (irq_req),
        .irq_mask_i (irq_mask),
        .cpu_ack_i  (cpu_ack),
        .cpu_eoi_i  (cpu_eoi),
        .cpu_irq_o  (cpu_irq),
        .cpu_vec_o  (cpu_vec),
        .irq_clr_o  (irq_clr),
        .busy_o     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic vec_t mk(input logic r, input logic [7:0] q, input logic [7:0] m,
                                input logic a, input logic e, input logic ei,
                                input logic [2:0] ev, input logic [7:0] ec, input logic eb);
        vec_t v;
        v.rst_n = r;  v.req = q;  v.mask = m;  v.ack = a;  v.eoi = e;
        v.irq = ei;   v.vec = ev; v.clr = ec;  v.busy = eb;
        return v;
    endfunction

    task automatic check(input string name, input int idx, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: actual=%0h required=%0h", name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input int idx, input logic ei,
                             input logic [2:0] ev, input logic [7:0] ec, input logic eb);
        check({tag, "_irq"}, idx, 32'(cpu_irq), 32'(ei));
        check({tag, "_vec"}, idx, 32'(cpu_vec), 32'(ev));
        check({tag, "_clr"}, idx, 32'(irq_clr), 32'(ec));
        check({tag, "_busy"}, idx, 32'(busy), 32'(eb));
    endtask

    initial begin
        logic [2:0] rr_exp[4];

        //                    rst  req    mask   ack  eoi  irq  vec   clr    busy
        tbl.push_back(mk(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));
        tbl.push_back(mk(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));
        tbl.push_back(mk(1'b0, 8'hFF, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));
        // single source 4
        tbl.push_back(mk(1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h00, 1'b1));
        tbl.push_back(mk(1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h00, 1'b1));
        tbl.push_back(mk(1'b1, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 3'd4, 8'h10, 1'b1));
        tbl.push_back(mk(1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 3'd4, 8'h00, 1'b1));
        tbl.push_back(mk(1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd4, 8'h00, 1'b0));
        tbl.push_back(mk(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));
        // simultaneous 2 and 5
        tbl.push_back(mk(1'b1, 8'h24, 8'h00, 1'b0, 1'b0, 1'b1, 3'd2, 8'h00, 1'b1));
        tbl.push_back(mk(1'b1, 8'h24, 8'h00, 1'b1, 1'b0, 1'b0, 3'd2, 8'h04, 1'b1));
        tbl.push_back(mk(1'b1, 8'h20, 8'h00, 1'b0, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0));
        tbl.push_back(mk(1'b1, 8'h20, 8'h00, 1'b0, 1'b0, 1'b1, 3'd5, 8'h00, 1'b1));
        // withdrawal by mask
        tbl.push_back(mk(1'b1, 8'h20, 8'h20, 1'b0, 1'b0, 1'b0, 3'd5, 8'h00, 1'b0));
        tbl.push_back(mk(1'b1, 8'h20, 8'h20, 1'b0, 1'b0, 1'b0, 3'd5, 8'h00, 1'b0));
        tbl.push_back(mk(1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h00, 1'b1));
        tbl.push_back(mk(1'b1, 8'h10, 8'h10, 1'b0, 1'b0, 1'b0, 3'd4, 8'h00, 1'b0));
        tbl.push_back(mk(1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b1, 3'd4, 8'h00, 1'b1));
        // ack together with withdrawal: ack wins
        tbl.push_back(mk(1'b1, 8'h10, 8'h10, 1'b1, 1'b0, 1'b0, 3'd4, 8'h10, 1'b1));
        tbl.push_back(mk(1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0, 3'd4, 8'h00, 1'b1));
        // ack ignored in SERVICE and in IDLE
        tbl.push_back(mk(1'b1, 8'h10, 8'h00, 1'b1, 1'b0, 1'b0, 3'd4, 8'h00, 1'b1));
        tbl.push_back(mk(1'b1, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 3'd4, 8'h00, 1'b0));
        tbl.push_back(mk(1'b1, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0, 3'd4, 8'h00, 1'b0));
        // eoi ignored in PEND; ack+eoi is ack only
        tbl.push_back(mk(1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b1, 3'd0, 8'h00, 1'b1));
        tbl.push_back(mk(1'b1, 8'h01, 8'h00, 1'b0, 1'b1, 1'b1, 3'd0, 8'h00, 1'b1));
        tbl.push_back(mk(1'b1, 8'h01, 8'h00, 1'b1, 1'b1, 1'b0, 3'd0, 8'h01, 1'b1));
        tbl.push_back(mk(1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1));
        // reset while in SERVICE: no pulse
        tbl.push_back(mk(1'b0, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));
        tbl.push_back(mk(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 1'b0));

        rst_n    = 1'b0;
        irq_req  = 8'hFF;
        irq_mask = 8'h00;
        cpu_ack  = 1'b0;
        cpu_eoi  = 1'b0;
        #2;

        foreach (tbl[i]) begin
            rst_n    = tbl[i].rst_n;
            irq_req  = tbl[i].req;
            irq_mask = tbl[i].mask;
            cpu_ack  = tbl[i].ack;
            cpu_eoi  = tbl[i].eoi;
            step();
            check_all("vec", i, tbl[i].irq, tbl[i].vec, tbl[i].clr, tbl[i].busy);
        end

        // Both sources held: repeated ack/eoi shows the arbitration policy.
`ifdef IRQ_ARB_ROUND_ROBIN_EN
        rr_exp[0] = 3'd0; rr_exp[1] = 3'd7; rr_exp[2] = 3'd0; rr_exp[3] = 3'd7;
`else
        rr_exp[0] = 3'd0; rr_exp[1] = 3'd0; rr_exp[2] = 3'd0; rr_exp[3] = 3'd0;
`endif
        rst_n   = 1'b0;
        cpu_ack = 1'b0;
        cpu_eoi = 1'b0;
        irq_req = 8'h81;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            check_all("seq_pend", k, 1'b1, rr_exp[k], 8'h00, 1'b1);
            cpu_ack = 1'b1;
            step();
            check_all("seq_ack", k, 1'b0, rr_exp[k], 8'h01 << rr_exp[k], 1'b1);
            cpu_ack = 1'b0;
            cpu_eoi = 1'b1;
            step();
            check_all("seq_eoi", k, 1'b0, rr_exp[k], 8'h00, 1'b0);
            cpu_eoi = 1'b0;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
